apb_dual_requester_arbiter: RTL and testbench

//  Shares one downstream APB completer bus (e.g. mdio/relay/crossbar segment) between two APB requesters:

---
 rtl/apb_dual_requester_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_apb_dual_requester_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_dual_requester_arbiter.sv
// apb_dual_requester_arbiter: shares one downstream APB completer between two
// APB requesters (port 0 = QSPI management bridge, port 1 = on-chip sequencer).
// Round-robin arbitration with one transfer in flight. The downstream transfer
// is driven from registered copies, so there is no combinational path through
// the arbiter.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without dn_pready. The abort returns pslverr=1 and prdata=0.
module apb_dual_requester_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                up_psel,
    input  logic [1:0]                up_penable,
    input  logic [1:0]                up_pwrite,
    input  logic [2*ADDR_WIDTH-1:0]   up_paddr,
    input  logic [2*DATA_WIDTH-1:0]   up_pwdata,
    output logic [1:0]                up_pready,
    output logic [DATA_WIDTH-1:0]     up_prdata,
    output logic                      up_pslverr,
    output logic                      dn_psel,
    output logic                      dn_penable,
    output logic                      dn_pwrite,
    output logic [ADDR_WIDTH-1:0]     dn_paddr,
    output logic [DATA_WIDTH-1:0]     dn_pwdata,
    input  logic                      dn_pready,
    input  logic [DATA_WIDTH-1:0]     dn_prdata,
    input  logic                      dn_pslverr,
    output logic [1:0]                grant
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;   // index of the port served last
    logic          win_idx;

    logic [1:0]    grant_d;
    logic          dn_psel_d, dn_penable_d, dn_pwrite_d;
    logic [AW-1:0] dn_paddr_d;
    logic [DW-1:0] dn_pwdata_d;
    logic [1:0]    up_pready_d;
    logic [DW-1:0] up_prdata_d;
    logic          up_pslverr_d;

    // Penable is not needed for arbitration: psel alone marks a pending request.
    logic          unused_ok;
    assign unused_ok = &{1'b0, up_penable};

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]   tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;

    // The counter holds the number of ACCESS cycles already spent.
    // The limit is reached on the last permitted ACCESS cycle.
    assign tmo_hit = (tmo_cnt_q == TMO_LIMIT);

    // ACCESS-phase cycle counter, cleared on entry to SETUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    // Round-robin winner: on a tie, pick the port that was not served last.
    always_comb begin
        win_idx = 1'b0;
        if (&up_psel) win_idx = ~last_grant_q;
        else          win_idx = up_psel[1];
    end

    // Next-state logic and next values for the registered outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant;
        dn_psel_d    = dn_psel;
        dn_penable_d = dn_penable;
        dn_pwrite_d  = dn_pwrite;
        dn_paddr_d   = dn_paddr;
        dn_pwdata_d  = dn_pwdata;
        up_pready_d  = 2'b00;
        up_prdata_d  = '0;
        up_pslverr_d = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|up_psel) begin
                    grant_d      = win_idx ? 2'b10 : 2'b01;
                    dn_psel_d    = 1'b1;
                    dn_penable_d = 1'b0;
                    dn_pwrite_d  = win_idx ? up_pwrite[1] : up_pwrite[0];
                    dn_paddr_d   = win_idx ? up_paddr[2*AW-1:AW] : up_paddr[AW-1:0];
                    dn_pwdata_d  = win_idx ? up_pwdata[2*DW-1:DW] : up_pwdata[DW-1:0];
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt_d    = '0;
`endif
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                dn_penable_d = 1'b1;
                state_d      = ST_ACCESS;
            end
            ST_ACCESS: begin
`ifdef APB_ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                if (dn_pready) begin
                    dn_psel_d    = 1'b0;
                    dn_penable_d = 1'b0;
                    up_pready_d  = grant;
                    up_prdata_d  = dn_pwrite ? '0 : dn_prdata;
                    up_pslverr_d = dn_pslverr;
                    state_d      = ST_RESP;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    dn_psel_d    = 1'b0;
                    dn_penable_d = 1'b0;
                    up_pready_d  = grant;
                    up_prdata_d  = '0;
                    up_pslverr_d = 1'b1;
                    state_d      = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                last_grant_d = grant[1];
                grant_d      = 2'b00;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                grant_d      = 2'b00;
                dn_psel_d    = 1'b0;
                dn_penable_d = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Registered outputs, including the latched downstream request copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= 2'b00;
            dn_psel    <= 1'b0;
            dn_penable <= 1'b0;
            dn_pwrite  <= 1'b0;
            dn_paddr   <= '0;
            dn_pwdata  <= '0;
            up_pready  <= 2'b00;
            up_prdata  <= '0;
            up_pslverr <= 1'b0;
        end else begin
            grant      <= grant_d;
            dn_psel    <= dn_psel_d;
            dn_penable <= dn_penable_d;
            dn_pwrite  <= dn_pwrite_d;
            dn_paddr   <= dn_paddr_d;
            dn_pwdata  <= dn_pwdata_d;
            up_pready  <= up_pready_d;
            up_prdata  <= up_prdata_d;
            up_pslverr <= up_pslverr_d;
        end
    end

endmodule

// File: tb/tb_apb_dual_requester_arbiter.sv
// Directed bench for apb_dual_requester_arbiter (DW=16, AW=24, TIMEOUT_CYCLES=8).
// The timeout scenario runs only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_dual_requester_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  up_psel, up_penable, up_pwrite;
    logic [47:0] up_paddr;
    logic [31:0] up_pwdata;
    logic [1:0]  up_pready;
    logic [15:0] up_prdata;
    logic        up_pslverr;
    logic        dn_psel, dn_penable, dn_pwrite;
    logic [23:0] dn_paddr;
    logic [15:0] dn_pwdata;
    logic        dn_pready;
    logic [15:0] dn_prdata;
    logic        dn_pslverr;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    apb_dual_requester_arbiter #(
        .DATA_WIDTH(16), .ADDR_WIDTH(24), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .up_psel(up_psel), .up_penable(up_penable), .up_pwrite(up_pwrite),
        .up_paddr(up_paddr), .up_pwdata(up_pwdata),
        .up_pready(up_pready), .up_prdata(up_prdata), .up_pslverr(up_pslverr),
        .dn_psel(dn_psel), .dn_penable(dn_penable), .dn_pwrite(dn_pwrite),
        .dn_paddr(dn_paddr), .dn_pwdata(dn_pwdata),
        .dn_pready(dn_pready), .dn_prdata(dn_prdata), .dn_pslverr(dn_pslverr),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_grant [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        rst = 1'b1;
        up_psel = '0; up_penable = '0; up_pwrite = '0;
        up_paddr = '0; up_pwdata = '0;
        dn_pready = 1'b0; dn_prdata = '0; dn_pslverr = 1'b0;
        tick();
        tick();
        check("rst_grant",   32'(grant), 32'h0);
        check("rst_dn_psel", 32'(dn_psel), 32'h0);
        check("rst_pready",  32'(up_pready), 32'h0);
        check("rst_paddr",   32'(dn_paddr), 32'h0);
        rst = 1'b0;

        // Port 0 single read with a zero-wait completer.
        dn_pready = 1'b1; dn_prdata = 16'hBEEF; dn_pslverr = 1'b0;
        up_psel = 2'b01; up_pwrite = 2'b00; up_paddr[23:0] = 24'h000404;
        tick();
        check("t1_c1_psel",    32'(dn_psel), 32'h1);
        check("t1_c1_penable", 32'(dn_penable), 32'h0);
        check("t1_c1_paddr",   32'(dn_paddr), 32'h000404);
        check("t1_c1_grant",   32'(grant), 32'h1);
        check("t1_c1_pready",  32'(up_pready), 32'h0);
        up_penable = 2'b01;
        tick();
        check("t1_c2_psel",    32'(dn_psel), 32'h1);
        check("t1_c2_penable", 32'(dn_penable), 32'h1);
        tick();
        check("t1_c3_pready",  32'(up_pready), 32'h1);
        check("t1_c3_prdata",  32'(up_prdata), 32'hBEEF);
        check("t1_c3_pslverr", 32'(up_pslverr), 32'h0);
        check("t1_c3_dn_psel", 32'(dn_psel), 32'h0);
        tick();
        up_psel = 2'b00; up_penable = 2'b00;
        check("t1_c4_pready",  32'(up_pready), 32'h0);
        check("t1_c4_prdata",  32'(up_prdata), 32'h0);
        check("t1_c4_grant",   32'(grant), 32'h0);

        // Simultaneous writes after reset: port 0 first, then port 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        up_psel = 2'b11; up_pwrite = 2'b11;
        up_paddr = {24'h000020, 24'h000010};
        up_pwdata = {16'h2222, 16'h1111};
        tick();
        check("t2_a_grant",  32'(grant), 32'h1);
        check("t2_a_pwdata", 32'(dn_pwdata), 32'h1111);
        check("t2_a_pwrite", 32'(dn_pwrite), 32'h1);
        check("t2_a_paddr",  32'(dn_paddr), 32'h000010);
        up_penable = 2'b11;
        tick();
        tick();
        check("t2_a_pready", 32'(up_pready), 32'h1);
        check("t2_a_prdata", 32'(up_prdata), 32'h0);
        tick();
        up_psel = 2'b10; up_penable = 2'b10;
        check("t2_idle_grant", 32'(grant), 32'h0);
        tick();
        check("t2_b_grant",  32'(grant), 32'h2);
        check("t2_b_pwdata", 32'(dn_pwdata), 32'h2222);
        check("t2_b_paddr",  32'(dn_paddr), 32'h000020);
        tick();
        tick();
        check("t2_b_pready", 32'(up_pready), 32'h2);
        tick();
        up_psel = 2'b00; up_penable = 2'b00;

        // Both ports requesting continuously: grants alternate starting at port 0.
        up_psel = 2'b11; up_penable = 2'b11; up_pwrite = 2'b00;
        up_paddr = {24'h000200, 24'h000100};
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t3_grant", 32'(grant), 32'(exp_grant[i]));
            check("t3_paddr", 32'(dn_paddr), (i % 2 == 0) ? 32'h000100 : 32'h000200);
            tick();
            tick();
            check("t3_pready", 32'(up_pready), 32'(exp_grant[i]));
            tick();
            check("t3_idle", 32'(grant), 32'h0);
        end
        up_psel = 2'b00; up_penable = 2'b00;

        // Five wait states with slave error; upstream changes during ACCESS are ignored.
        dn_pready = 1'b0; dn_pslverr = 1'b0; dn_prdata = 16'h5A5A;
        up_psel = 2'b01; up_paddr[23:0] = 24'h00ABCD; up_pwdata[15:0] = 16'h0042;
        tick();
        up_penable = 2'b01; up_paddr[23:0] = 24'hFFFFFF; up_pwdata[15:0] = 16'hFFFF;
        for (int w = 0; w < 5; w++) begin
            tick();
            check("t4_wait_penable", 32'(dn_penable), 32'h1);
            check("t4_wait_paddr",   32'(dn_paddr), 32'h00ABCD);
            check("t4_wait_pwdata",  32'(dn_pwdata), 32'h0042);
            check("t4_wait_pready",  32'(up_pready), 32'h0);
        end
        tick();
        check("t4_last_penable", 32'(dn_penable), 32'h1);
        check("t4_last_pready",  32'(up_pready), 32'h0);
        dn_pready = 1'b1; dn_pslverr = 1'b1;
        tick();
        check("t4_pready",  32'(up_pready), 32'h1);
        check("t4_pslverr", 32'(up_pslverr), 32'h1);
        check("t4_prdata",  32'(up_prdata), 32'h5A5A);
        dn_pready = 1'b0; dn_pslverr = 1'b0;
        tick();
        up_psel = 2'b00; up_penable = 2'b00;
        check("t4_after_pready",  32'(up_pready), 32'h0);
        check("t4_after_pslverr", 32'(up_pslverr), 32'h0);

        // Asynchronous reset in ACCESS, then a normal port 1 read.
        up_psel = 2'b01; up_paddr[23:0] = 24'h000300;
        tick();
        tick();
        check("t5_access", 32'(dn_penable), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_psel",    32'(dn_psel), 32'h0);
        check("t5_rst_penable", 32'(dn_penable), 32'h0);
        check("t5_rst_grant",   32'(grant), 32'h0);
        check("t5_rst_paddr",   32'(dn_paddr), 32'h0);
        check("t5_rst_pready",  32'(up_pready), 32'h0);
        up_psel = 2'b00; up_penable = 2'b00;
        tick();
        rst = 1'b0;
        dn_pready = 1'b1; dn_prdata = 16'h1234;
        up_psel = 2'b10; up_pwrite = 2'b00; up_paddr[47:24] = 24'h000777;
        tick();
        check("t5_grant", 32'(grant), 32'h2);
        check("t5_paddr", 32'(dn_paddr), 32'h000777);
        tick();
        tick();
        check("t5_pready", 32'(up_pready), 32'h2);
        check("t5_prdata", 32'(up_prdata), 32'h1234);
        tick();
        up_psel = 2'b00;

`ifdef APB_ARB_TIMEOUT_EN
        // Completer never readies: abort after 8 ACCESS cycles, then a normal read.
        dn_pready = 1'b0; dn_prdata = 16'hCAFE;
        up_psel = 2'b01; up_paddr[23:0] = 24'h000500;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_access_penable", 32'(dn_penable), 32'h1);
            check("t6_access_pready",  32'(up_pready), 32'h0);
        end
        tick();
        check("t6_tmo_pready",  32'(up_pready), 32'h1);
        check("t6_tmo_pslverr", 32'(up_pslverr), 32'h1);
        check("t6_tmo_prdata",  32'(up_prdata), 32'h0);
        check("t6_tmo_dn_psel", 32'(dn_psel), 32'h0);
        tick();
        up_psel = 2'b10; dn_pready = 1'b1;
        tick();
        check("t6_next_grant", 32'(grant), 32'h2);
        tick();
        tick();
        check("t6_next_pready",  32'(up_pready), 32'h2);
        check("t6_next_prdata",  32'(up_prdata), 32'hCAFE);
        check("t6_next_pslverr", 32'(up_pslverr), 32'h0);
        tick();
        up_psel = 2'b00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
